// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow error pulses and a
// selectable first-word-fall-through read mode.
//
// Parameters:
//   WIDTH    data word width
//   DEPTH    number of entries (power of two, >= 2)
//   AF_LEVEL almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL almost_empty asserts when count <= AE_LEVEL
//   FWFT     0 = registered read, 1 = first-word-fall-through
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, data_in     write request and data
//   pop               read request
//   data_out          read data
//   full, empty       count == DEPTH / count == 0
//   almost_full/empty threshold flags from count
//   count             occupancy 0..DEPTH
//   overflow          one-cycle pulse after a rejected push
//   underflow         one-cycle pulse after a rejected pop
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO is still accepted when a pop frees the head
  // slot on the same edge.
  always_comb begin
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
  end

  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && !wr_en;
      underflow <= pop && !rd_en;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented combinationally; zero while empty.
      always_comb begin
        data_out = empty ? '0 : mem[rd_ptr];
      end
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        data_out <= '0;
        else if (rd_en) data_out <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst;
  // Standard-read instance
  logic       push0, pop0;
  logic [7:0] din0, dout0;
  logic       full0, empty0, af0, ae0, ov0, un0;
  logic [4:0] cnt0;
  // FWFT instance
  logic       push1, pop1;
  logic [7:0] din1, dout1;
  logic       full1, empty1, af1, ae1, ov1, un1;
  logic [4:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .push(push0), .data_in(din0), .pop(pop0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .push(push1), .data_in(din1), .pop(pop1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  typedef struct {
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic [4:0] cnt;
    logic       ov;
    logic       un;
    logic       dchk;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] model[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(logic p, logic [7:0] d, logic q, logic [4:0] c,
                              logic o, logic u, logic dc, logic [7:0] dv);
    vec_t v;
    v.push = p; v.din = d; v.pop = q; v.cnt = c;
    v.ov = o; v.un = u; v.dchk = dc; v.dout = dv;
    vecs.push_back(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_flags0(input string tag, input logic [4:0] c);
    check({tag, " count"}, 32'(cnt0), 32'(c));
    check({tag, " full"}, 32'(full0), 32'(c == 5'd16));
    check({tag, " empty"}, 32'(empty0), 32'(c == 5'd0));
    check({tag, " almost_full"}, 32'(af0), 32'(c >= 5'd14));
    check({tag, " almost_empty"}, 32'(ae0), 32'(c <= 5'd2));
  endtask

  initial begin
    rst = 1'b1;
    push0 = 0; pop0 = 0; din0 = '0;
    push1 = 0; pop1 = 0; din1 = '0;

    // Table: push, din, pop, count, overflow, underflow, check dout, dout
    for (int i = 0; i < 16; i++) add(1, 8'(i + 1), 0, 5'(i + 1), 0, 0, 0, 8'h00);
    add(1, 8'hAA, 0, 5'd16, 1, 0, 0, 8'h00);               // rejected push
    add(0, 8'h00, 0, 5'd16, 0, 0, 0, 8'h00);               // pulse ends
    for (int i = 0; i < 16; i++) add(0, 8'h00, 1, 5'(15 - i), 0, 0, 1, 8'(i + 1));
    add(0, 8'h00, 1, 5'd0, 0, 1, 1, 8'h10);                // underflow, dout holds
    add(0, 8'h00, 0, 5'd0, 0, 0, 1, 8'h10);
    for (int i = 0; i < 16; i++) add(1, 8'(8'h21 + i), 0, 5'(i + 1), 0, 0, 0, 8'h00);
    add(1, 8'h55, 1, 5'd16, 0, 0, 1, 8'h21);               // push+pop while full
    for (int i = 0; i < 16; i++)
      add(0, 8'h00, 1, 5'(15 - i), 0, 0, 1, (i < 15) ? 8'(8'h22 + i) : 8'h55);
    add(1, 8'h33, 1, 5'd1, 0, 1, 1, 8'h55);                // push+pop while empty
    add(0, 8'h00, 1, 5'd0, 0, 0, 1, 8'h33);

    tick; tick;
    rst = 1'b0;
    check_flags0("reset", 5'd0);
    check("reset dout0", 32'(dout0), 32'h0);
    check("reset dout1", 32'(dout1), 32'h0);
    check("reset empty1", 32'(empty1), 32'h1);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      push0 = vecs[i].push; din0 = vecs[i].din; pop0 = vecs[i].pop;
      tick;
      check_flags0(tag, vecs[i].cnt);
      check({tag, " overflow"}, 32'(ov0), 32'(vecs[i].ov));
      check({tag, " underflow"}, 32'(un0), 32'(vecs[i].un));
      if (vecs[i].dchk) check({tag, " data_out"}, 32'(dout0), 32'(vecs[i].dout));
    end
    push0 = 0; pop0 = 0;

    // Asynchronous reset mid-stream with five words queued.
    for (int i = 0; i < 5; i++) begin
      push0 = 1; din0 = 8'(8'h61 + i);
      tick;
    end
    push0 = 0;
    check("pre-reset count", 32'(cnt0), 32'd5);
    #1 rst = 1'b1;
    #1;
    check_flags0("async reset", 5'd0);
    check("async reset dout", 32'(dout0), 32'h0);
    #1 rst = 1'b0;
    // First edge after release: push accepted, pop rejected.
    push0 = 1; din0 = 8'h77; pop0 = 1;
    tick;
    check("post-reset underflow", 32'(un0), 32'h1);
    check_flags0("post-reset push", 5'd1);
    push0 = 0; pop0 = 0;
    tick;
    check("underflow clears", 32'(un0), 32'h0);
    pop0 = 1;
    tick;
    pop0 = 0;
    check("post-reset data", 32'(dout0), 32'h77);
    check("post-reset drained", 32'(empty0), 32'h1);

    // FWFT with pointer wrap: head word always presented.
    begin
      logic [7:0] dval;
      dval = 8'h01;
      for (int k = 0; k < 40; k++) begin
        push1 = (k % 3 != 2); pop1 = (k % 2 == 1); din1 = dval;
        check($sformatf("fwft%0d empty", k), 32'(empty1), 32'(model.size() == 0));
        check($sformatf("fwft%0d count", k), 32'(cnt1), 32'(model.size()));
        if (model.size() > 0) check($sformatf("fwft%0d head", k), 32'(dout1), 32'(model[0]));
        else                  check($sformatf("fwft%0d idle", k), 32'(dout1), 32'h0);
        tick;
        if (pop1 && model.size() > 0) void'(model.pop_front());
        if (push1) begin
          model.push_back(dval);
          dval++;
        end
      end
      push1 = 0; pop1 = 1;
      for (int k = 0; k < 20 && model.size() > 0; k++) begin
        check($sformatf("drain%0d head", k), 32'(dout1), 32'(model[0]));
        tick;
        void'(model.pop_front());
      end
      pop1 = 0;
      check("fwft final empty", 32'(empty1), 32'h1);
      check("fwft final dout", 32'(dout1), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
